// File: rtl/nios_nios2_qsys_0_mul_seq.sv
// Two-pass 32x32 -> low-32 multiply sequencer in front of the 16x16 partial-product cell.
// Pass 1 feeds the full operands (lo1*lo2 + hi1*lo2<<16). Pass 2 feeds the swapped
// halves so that the cell produces the missing lo1*hi2<<16 term. The two results are summed.
module nios_nios2_qsys_0_mul_seq #(
    parameter int unsigned CELL_LATENCY  = 1,
    parameter bit          ZERO_IDLE_OPS = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic        kill,
    output logic [31:0] mul_cell_src1,
    output logic [31:0] mul_cell_src2,
    input  logic [31:0] mul_cell_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    // The counter must reach CELL_LATENCY+1 without wrapping.
    localparam int unsigned      CNT_W   = $clog2(CELL_LATENCY + 2) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(CELL_LATENCY);
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(CELL_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      res_q, res_d;
    logic             accept;

    assign in_ready   = (state_q == S_IDLE) && !kill;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == S_OUT);
    assign out_result = res_q;

    // FSM next state; kill overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_FIN) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Datapath next values: latch operands, count passes, capture the two cell results.
    always_comb begin
        cnt_d = cnt_q;
        op1_d = op1_q;
        op2_d = op2_q;
        acc_d = acc_q;
        res_d = res_q;
        if (kill) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            op1_d = in_src1;
            op2_d = in_src2;
            cnt_d = '0;
            acc_d = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_ACC) acc_d = mul_cell_result;
            if (cnt_q == CNT_FIN) res_d = acc_q + mul_cell_result;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    // Cell operands are decoded straight from state/cnt/op registers, so they reset to 0
    // and appear in the same cycle as the count. "Hold" mode keeps presenting pass-2 values.
    always_comb begin
        if (state_q == S_RUN && cnt_q == '0) begin
            mul_cell_src1 = op1_q;
            mul_cell_src2 = op2_q;
        end else if ((state_q == S_RUN && cnt_q == CNT_ONE) || !ZERO_IDLE_OPS) begin
            mul_cell_src1 = {op2_q[31:16], 16'h0000};
            mul_cell_src2 = {16'h0000, op1_q[15:0]};
        end else begin
            mul_cell_src1 = '0;
            mul_cell_src2 = '0;
        end
    end

endmodule
